// File: rtl/dmem_access_pkg.sv
// Shared constants for the data-memory access block: word width, RISC-V
// load/store funct3 encodings and the request legality check.
package dmem_access_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // High when the funct3 is undefined for the access type or the address is misaligned.
  function automatic logic req_is_err(input logic       wen,
                                      input logic [2:0] funct3,
                                      input logic [1:0] byte_off);
    logic err;
    err = 1'b0;
    if (wen) begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = byte_off[0];
        F3_SW:   err = (byte_off != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = byte_off[0];
        F3_LW:         err = (byte_off != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_access_lane.sv
// Combinational lane logic: little-endian lane extract with sign/zero extension
// for loads, and byte/halfword merge into the fetched word for stores.
module dmem_lane
  import dmem_access_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          byte_off,
  input  logic [WORD_LEN-1:0] rdata,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] load_data,
  output logic [WORD_LEN-1:0] merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword from the fetched word.
  always_comb begin
    w_byte = 8'h00;
    case (byte_off)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (byte_off[1]) begin
      w_half = rdata[31:16];
    end else begin
      w_half = rdata[15:0];
    end
  end

  // Extend the selected lane into the load result.
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_LB:   load_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  load_data = {24'h00_0000, w_byte};
      F3_LH:   load_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  load_data = {16'h0000, w_half};
      F3_LW:   load_data = rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Overlay the store lane onto the fetched word for read-modify-write.
  always_comb begin
    merge_data = rdata;
    case (funct3)
      F3_SB: begin
        case (byte_off)
          2'd0:    merge_data = {rdata[31:8], wdata[7:0]};
          2'd1:    merge_data = {rdata[31:16], wdata[7:0], rdata[7:0]};
          2'd2:    merge_data = {rdata[31:24], wdata[7:0], rdata[15:0]};
          2'd3:    merge_data = {wdata[7:0], rdata[23:0]};
          default: merge_data = rdata;
        endcase
      end
      F3_SH: begin
        if (byte_off[1]) begin
          merge_data = {wdata[15:0], rdata[15:0]};
        end else begin
          merge_data = {rdata[31:16], wdata[15:0]};
        end
      end
      F3_SW:   merge_data = wdata;
      default: merge_data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// Load/store unit between the CPU and a word-wide memory with one-cycle
// synchronous read; sub-word stores are done as read-modify-write.
module dmem_access
  import dmem_access_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] mem_addr,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_wen;
  logic [2:0]          r_funct3;
  logic [1:0]          r_byte_off;
  logic [WORD_LEN-1:0] r_wdata;
  logic [WORD_LEN-1:0] r_mem_addr;
  logic [WORD_LEN-1:0] r_mem_wdata;
  logic                r_mem_wen;
  logic                r_resp_valid;
  logic [WORD_LEN-1:0] r_resp_rdata;
  logic                r_resp_err;
  logic                w_accept;
  logic                w_req_err;
  logic [WORD_LEN-1:0] w_load_data;
  logic [WORD_LEN-1:0] w_merge_data;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_req_err = req_is_err(req_wen, req_funct3, req_addr[1:0]);

  dmem_lane u_lane (
    .funct3     (r_funct3),
    .byte_off   (r_byte_off),
    .rdata      (mem_rdata),
    .wdata      (r_wdata),
    .load_data  (w_load_data),
    .merge_data (w_merge_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: SW skips the read, sub-word stores read then write.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_accept) begin
          w_state_nxt = IDLE;
        end else if (w_req_err) begin
          w_state_nxt = RESP;
        end else if (req_wen && (req_funct3 == F3_SW)) begin
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = ADDR;
        end
      end
      ADDR:    w_state_nxt = DATA;
      DATA: begin
        if (r_wen) begin
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      WRITE:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, memory-port and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen        <= 1'b0;
      r_funct3     <= 3'b000;
      r_byte_off   <= 2'b00;
      r_wdata      <= 32'h0000_0000;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_mem_wen    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
    end else begin
      r_mem_wen    <= (w_state_nxt == WRITE);
      r_resp_valid <= (w_state_nxt == RESP);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wen      <= req_wen;
            r_funct3   <= req_funct3;
            r_byte_off <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_mem_addr <= {req_addr[WORD_LEN-1:2], 2'b00};
            if (w_state_nxt == WRITE) begin
              r_mem_wdata <= req_wdata;
            end
            if (w_state_nxt == RESP) begin
              r_resp_rdata <= 32'h0000_0000;
              r_resp_err   <= 1'b1;
            end
          end
        end
        DATA: begin
          // mem_rdata here is the word addressed since acceptance.
          if (r_wen) begin
            r_mem_wdata <= w_merge_data;
          end else begin
            r_resp_rdata <= w_load_data;
            r_resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          r_resp_rdata <= 32'h0000_0000;
          r_resp_err   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wen    = r_mem_wen;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access.sv
// Scoreboard bench for dmem_access: directed requests push expected responses,
// a negedge monitor checks every response and memory write against the queues.
module tb_dmem_access;
  import dmem_access_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_wdata;

  logic [31:0] mem [0:255];
  exp_t        exp_q[$];
  int          acc_q[$];
  logic [63:0] wexp_q[$];
  int          cyc = 0;
  int          last_resp = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  dmem_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[64] = 32'h8899_AABB;
  end

  // One-cycle synchronous-read memory with word write.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: record acceptances, check responses and writes against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
    end else begin
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      if (resp_valid) begin
        last_resp = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("latency", 32'(cyc - a + 1), 32'(e.lat));
        end
      end
      if (mem_wen) begin
        if (wexp_q.size() == 0) begin
          chk("unexpected_mem_wen", 32'd1, 32'd0);
        end else begin
          logic [63:0] w;
          w = wexp_q.pop_front();
          chk("mem_wen_addr", mem_addr, w[63:32]);
          chk("mem_wdata", mem_wdata, w[31:0]);
        end
      end
    end
  end

  task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input bit keep,
                        input bit track, output int acc);
    exp_t e;
    bit   ok;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    if (track) exp_q.push_back(e);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        ok  = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: req_ready never seen for addr 0x%08h", addr);
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && req_ready) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0000_0000;
    req_wdata  = 32'h0000_0000;
    @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0000_0000);
    chk("rst_mem_addr", mem_addr, 32'h0000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads from the preset word.
    do_req(1'b0, F3_LW,  32'h100, 32'h0, 32'h8899_AABB, 1'b0, 3, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LB,  32'h103, 32'h0, 32'hFFFF_FF88, 1'b0, 3, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LBU, 32'h103, 32'h0, 32'h0000_0088, 1'b0, 3, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LH,  32'h102, 32'h0, 32'hFFFF_8899, 1'b0, 3, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LHU, 32'h100, 32'h0, 32'h0000_AABB, 1'b0, 3, 1'b0, 1'b1, acc); drain();

    // Byte store read-modify-write, then read back.
    wexp_q.push_back({32'h100, 32'h8899_77BB});
    do_req(1'b1, F3_SB, 32'h101, 32'h1234_5677, 32'h0, 1'b0, 4, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LW, 32'h100, 32'h0, 32'h8899_77BB, 1'b0, 3, 1'b0, 1'b1, acc); drain();

    // Error cases: misaligned and illegal funct3, no write expected.
    do_req(1'b1, F3_SH,  32'h101, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LW,  32'h102, 32'h0,         32'h0, 1'b1, 1, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, 3'b011, 32'h100, 32'h0,         32'h0, 1'b1, 1, 1'b0, 1'b1, acc); drain();
    do_req(1'b1, 3'b011, 32'h100, 32'h5555_5555, 32'h0, 1'b1, 1, 1'b0, 1'b1, acc); drain();
    do_req(1'b1, F3_SW,  32'h102, 32'h5555_5555, 32'h0, 1'b1, 1, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LHU, 32'h103, 32'h0,         32'h0, 1'b1, 1, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LW,  32'h100, 32'h0, 32'h8899_77BB, 1'b0, 3, 1'b0, 1'b1, acc); drain();

    // Reset asserted while the halfword store is in DATA.
    do_req(1'b1, F3_SH, 32'h100, 32'h0000_1111, 32'h0, 1'b0, 0, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    do_req(1'b0, F3_LW, 32'h100, 32'h0, 32'h8899_77BB, 1'b0, 3, 1'b0, 1'b1, acc); drain();

    // Upper-halfword store, then positive sign-extension cases.
    wexp_q.push_back({32'h100, 32'hCAFE_77BB});
    do_req(1'b1, F3_SH, 32'h102, 32'h1234_CAFE, 32'h0, 1'b0, 4, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LW, 32'h100, 32'h0, 32'hCAFE_77BB, 1'b0, 3, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LB, 32'h101, 32'h0, 32'h0000_0077, 1'b0, 3, 1'b0, 1'b1, acc); drain();
    do_req(1'b0, F3_LH, 32'h100, 32'h0, 32'h0000_77BB, 1'b0, 3, 1'b0, 1'b1, acc); drain();

    // Held req_valid: SW then LW back-to-back.
    wexp_q.push_back({32'h104, 32'hDEAD_BEEF});
    do_req(1'b1, F3_SW, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1, 1'b1, acc);
    do_req(1'b0, F3_LW, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 1'b1, acc2);
    chk("held_accept_edge", 32'(acc2), 32'(last_resp + 2));
    drain();

    chk("wexp_drained", 32'(wexp_q.size()), 32'd0);
    chk("mem_word_100", mem[64], 32'hCAFE_77BB);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
